rom_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the 8-bit program ROM (256 x 8, synchronous read: DATA registered on posedge CLK from ADDR sampled at that edge).
- Drives the ROM address, captures returned bytes into a small prefetch FIFO, and presents them one byte at a time to the processor decoder over a valid/ready handshake, each byte tagged with its address.
- Supports redirect (jump/branch), which flushes all prefetched and in-flight bytes.

---
 rtl/rom_fetch_unit.sv | 126 ++++++++++++
 tb/tb_rom_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : rom_fetch_unit
// Description : Instruction fetch for a synchronous-read program ROM with a
//               prefetch FIFO, valid/ready byte delivery and jump flushing.
// Revision    : 1.0  initial release
// ============================================================================
module rom_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                             CLK,
  input  logic                             RESET,
  output logic [ADDR_WIDTH-1:0]            ROM_ADDR,
  input  logic [DATA_WIDTH-1:0]            ROM_DATA,
  input  logic                             JUMP_EN,
  input  logic [ADDR_WIDTH-1:0]            JUMP_ADDR,
  output logic                             INSTR_VALID,
  input  logic                             INSTR_READY,
  output logic [DATA_WIDTH-1:0]            INSTR_BYTE,
  output logic [ADDR_WIDTH-1:0]            INSTR_ADDR,
  output logic [$clog2(FIFO_DEPTH):0]      FIFO_LEVEL
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W:0]   C_DEPTH_OCC  = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] C_DEPTH_LVL  = LVL_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [LVL_W-1:0]      level_q, level_d;

  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];

  logic [LVL_W:0] occupancy;
  logic           issue;
  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic           fifo_full;

  // Occupancy counts the outstanding ROM read so a returning byte always has a slot.
  always_comb begin
    occupancy  = {1'b0, level_q} + {{LVL_W{1'b0}}, inflight_q};
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == C_DEPTH_LVL);
    issue      = !JUMP_EN && (occupancy < C_DEPTH_OCC);
    push       = inflight_q && !JUMP_EN;
    pop        = !fifo_empty && INSTR_READY && !JUMP_EN;
  end

  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    head_d          = head_q;
    tail_d          = tail_q;
    level_d         = level_q;
    if (JUMP_EN) begin
      fetch_pc_d = JUMP_ADDR;
      head_d     = '0;
      tail_d     = '0;
      level_d    = '0;
    end else begin
      if (issue) begin
        inflight_d      = 1'b1;
        inflight_addr_d = fetch_pc_q;
        fetch_pc_d      = fetch_pc_q + ADDR_WIDTH'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_q      <= RESET_VECTOR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      level_q         <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      level_q         <= level_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem_q[tail_q] <= ROM_DATA;
      addr_mem_q[tail_q] <= inflight_addr_q;
    end
  end

  assign ROM_ADDR    = fetch_pc_q;
  assign INSTR_VALID = !fifo_empty;
  assign INSTR_BYTE  = fifo_empty ? '0 : data_mem_q[head_q];
  assign INSTR_ADDR  = fifo_empty ? '0 : addr_mem_q[head_q];
  assign FIFO_LEVEL  = level_q;

  a_no_push_when_full: assert property (@(posedge CLK) disable iff (RESET) !(push && fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_fetch_unit
// Description : Scoreboard bench for rom_fetch_unit against a ROM of i^8'hA5.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rom_fetch_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA = 8'h00;
  logic       JUMP_EN = 1'b0;
  logic [7:0] JUMP_ADDR = 8'h00;
  logic       INSTR_VALID;
  logic       INSTR_READY = 1'b0;
  logic [7:0] INSTR_BYTE;
  logic [7:0] INSTR_ADDR;
  logic [2:0] FIFO_LEVEL;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  next_addr = 8'h00;

  rom_fetch_unit #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_DEPTH(4), .RESET_VECTOR(8'h00)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .JUMP_EN(JUMP_EN), .JUMP_ADDR(JUMP_ADDR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .INSTR_BYTE(INSTR_BYTE), .INSTR_ADDR(INSTR_ADDR),
    .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) ROM_DATA <= ROM_ADDR ^ 8'hA5;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_addr, next_addr ^ 8'hA5});
      next_addr = next_addr + 8'h01;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    refill();
  endtask

  task automatic jump(input logic [7:0] a);
    JUMP_EN   = 1'b1;
    JUMP_ADDR = a;
    exp_q.delete();
    next_addr = a;
    refill();
  endtask

  task automatic do_reset();
    JUMP_EN = 1'b0;
    RESET   = 1'b1;
    exp_q.delete();
    next_addr = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    refill();
  endtask

  // Monitor: every accepted byte is compared with the head of the expected queue.
  always @(negedge CLK) begin
    if (!RESET) begin
      check("level_bound", int'(FIFO_LEVEL <= 3'd4), 1);
      if (INSTR_VALID && INSTR_READY && !JUMP_EN) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("deliver_unexpected", int'({INSTR_ADDR, INSTR_BYTE}), -1);
        end else begin
          check("deliver", int'({INSTR_ADDR, INSTR_BYTE}), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int hs0;

    // Reset values and first-byte latency with the decoder always ready.
    INSTR_READY = 1'b1;
    #2;
    check("rst_valid", int'(INSTR_VALID), 0);
    check("rst_rom_addr", int'(ROM_ADDR), 8'h00);
    check("rst_level", int'(FIFO_LEVEL), 0);
    do_reset();
    tick();
    check("lat_edge1_valid", int'(INSTR_VALID), 0);
    check("lat_edge1_rom_addr", int'(ROM_ADDR), 8'h01);
    tick();
    check("lat_edge2_valid", int'(INSTR_VALID), 1);
    check("lat_edge2_head", int'({INSTR_ADDR, INSTR_BYTE}), 16'h00A5);
    hs0 = n_hs;
    repeat (300) tick();
    check("throughput_300", n_hs - hs0, 300);

    // Asynchronous reset between edges.
    #2;
    RESET = 1'b1;
    exp_q.delete();
    next_addr = 8'h00;
    #1;
    check("async_rst_valid", int'(INSTR_VALID), 0);
    check("async_rst_level", int'(FIFO_LEVEL), 0);
    check("async_rst_rom_addr", int'(ROM_ADDR), 8'h00);
    check("async_rst_head", int'({INSTR_ADDR, INSTR_BYTE}), 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    refill();
    tick();
    check("rerst_edge1_valid", int'(INSTR_VALID), 0);
    tick();
    check("rerst_edge2_head", int'({INSTR_ADDR, INSTR_BYTE}), 16'h00A5);
    repeat (10) tick();

    // Back-pressure: FIFO fills to 4 and fetch stops at 8'h04.
    INSTR_READY = 1'b0;
    do_reset();
    repeat (8) tick();
    check("sat_level", int'(FIFO_LEVEL), 4);
    check("sat_rom_addr", int'(ROM_ADDR), 8'h04);
    check("sat_valid", int'(INSTR_VALID), 1);
    check("sat_head", int'({INSTR_ADDR, INSTR_BYTE}), 16'h00A5);
    repeat (3) tick();
    check("sat_hold_head", int'({INSTR_ADDR, INSTR_BYTE}), 16'h00A5);
    check("sat_hold_rom_addr", int'(ROM_ADDR), 8'h04);
    INSTR_READY = 1'b1;
    hs0 = n_hs;
    repeat (20) tick();
    check("sat_release_count", n_hs - hs0, 20);

    // Jump with three bytes buffered and one read in flight.
    INSTR_READY = 1'b0;
    do_reset();
    repeat (4) tick();
    check("pre_jump_level", int'(FIFO_LEVEL), 3);
    jump(8'h40);
    tick();
    JUMP_EN = 1'b0;
    check("jump_flush_valid", int'(INSTR_VALID), 0);
    check("jump_flush_level", int'(FIFO_LEVEL), 0);
    check("jump_rom_addr", int'(ROM_ADDR), 8'h40);
    tick();
    check("jump_issue_valid", int'(INSTR_VALID), 0);
    check("jump_issue_rom_addr", int'(ROM_ADDR), 8'h41);
    tick();
    check("jump_first_valid", int'(INSTR_VALID), 1);
    check("jump_first_head", int'({INSTR_ADDR, INSTR_BYTE}), 16'h40E5);
    INSTR_READY = 1'b1;
    repeat (10) tick();

    // Consecutive jumps: only the second target is delivered.
    INSTR_READY = 1'b0;
    jump(8'h10);
    tick();
    jump(8'h20);
    tick();
    JUMP_EN = 1'b0;
    tick();
    tick();
    check("dbl_jump_head", int'({INSTR_ADDR, INSTR_BYTE}), 16'h2085);
    check("dbl_jump_level", int'(FIFO_LEVEL), 1);
    INSTR_READY = 1'b1;
    repeat (10) tick();

    // Random back-pressure with occasional jumps.
    for (int i = 0; i < 1000; i++) begin
      INSTR_READY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 5) jump(8'($urandom_range(0, 255)));
      else JUMP_EN = 1'b0;
      tick();
    end
    JUMP_EN = 1'b0;
    INSTR_READY = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
